// File: rtl/picorv32_mem_ram_if.sv
// picorv32_mem_ram_if
// -------------------
// The picorv32 native memory bus as one bundle.
//   mem_valid  core -> mem   request valid
//   mem_instr  core -> mem   request is an instruction fetch
//   mem_addr   core -> mem   byte address (bits [1:0] ignored by the RAM)
//   mem_wdata  core -> mem   write data
//   mem_wstrb  core -> mem   byte write enables, 4'b0000 = read
//   mem_ready  mem -> core   one-cycle completion strobe
//   mem_rdata  mem -> core   read data, valid while mem_ready is high
// Modports: master = the core side, slave = the memory side.
interface picorv32_mem_ram_if;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/picorv32_mem_ram.sv
// picorv32_mem_ram
// ----------------
// Word-organised on-chip RAM slave for the picorv32 native memory bus, with
// a byte-wide output port at OUT_ADDR, programmable wait states, an error
// strobe for accesses that hit nothing, and an instruction-fetch counter.
//
// Parameters:
//   MEM_WORDS    RAM depth in 32-bit words (>= 1)
//   BASE_ADDR    byte address of RAM word 0 (word-aligned)
//   WAIT_STATES  extra cycles before mem_ready (0..15)
//   OUT_ADDR     byte address of the output port (word-aligned, outside RAM)
// Ports:
//   clk          clock, rising edge
//   reset        synchronous active-high reset
//   bus          picorv32 memory bus, slave side
//   out_valid    one-cycle strobe on a write to OUT_ADDR
//   out_data     last byte written to OUT_ADDR
//   err          one-cycle strobe on an access that hits neither RAM nor port
//   fetch_count  number of completed instruction-fetch reads (wraps)
module picorv32_mem_ram #(
    parameter int          MEM_WORDS   = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] OUT_ADDR    = 32'h1000_0000
) (
    input  logic                      clk,
    input  logic                      reset,
    picorv32_mem_ram_if.slave         bus,
    output logic                      out_valid,
    output logic [7:0]                out_data,
    output logic                      err,
    output logic [31:0]               fetch_count
);

    localparam int          AW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [31:0] BASE_WORD = {2'b00, BASE_ADDR[31:2]};
    localparam logic [29:0] OUT_WORD  = OUT_ADDR[31:2];
    localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP, RECOVER} state_t;

    state_t        state;
    state_t        next_state;

    logic [31:0]   ram [0:MEM_WORDS-1];

    logic [31:0]   cur_offset;
    logic          cur_ram_hit;
    logic          cur_port_hit;
    logic [AW-1:0] cur_idx;

    logic [AW-1:0] lat_idx;
    logic [31:0]   lat_wdata;
    logic [3:0]    lat_wstrb;
    logic          lat_instr;
    logic          lat_ram_hit;
    logic          lat_port_hit;
    logic [3:0]    wait_cnt;

    logic          rd_ram_hit;
    logic          rd_port_hit;
    logic [AW-1:0] rd_idx;
    logic          accept;

    logic          addr_lsb_unused;
    assign addr_lsb_unused = ^bus.mem_addr[1:0];

    // A word below BASE wraps to a huge offset, so one unsigned compare
    // covers both ends of the RAM window.
    assign cur_offset   = {2'b00, bus.mem_addr[31:2]} - BASE_WORD;
    assign cur_ram_hit  = cur_offset < 32'(MEM_WORDS);
    assign cur_port_hit = bus.mem_addr[31:2] == OUT_WORD;
    assign cur_idx      = AW'(cur_offset);

    assign accept = (state == IDLE) && bus.mem_valid;

    // With no wait states the read happens on the accepting edge, before the
    // request has been latched, so the live decode feeds the read port.
    assign rd_ram_hit  = (state == IDLE) ? cur_ram_hit  : lat_ram_hit;
    assign rd_port_hit = (state == IDLE) ? cur_port_hit : lat_port_hit;
    assign rd_idx      = (state == IDLE) ? cur_idx      : lat_idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state    = state;
        bus.mem_ready = 1'b0;
        err           = 1'b0;
        out_valid     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.mem_valid) begin
                    next_state = (WAIT_STATES > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                // Dropping mem_valid here abandons the request silently.
                if (!bus.mem_valid) begin
                    next_state = IDLE;
                end else if (wait_cnt == 4'd0) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                next_state    = RECOVER;
                bus.mem_ready = 1'b1;
                err           = !lat_ram_hit && !lat_port_hit;
                out_valid     = lat_port_hit && (lat_wstrb != 4'h0);
            end
            RECOVER: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            lat_idx      <= cur_idx;
            lat_wdata    <= bus.mem_wdata;
            lat_wstrb    <= bus.mem_wstrb;
            lat_instr    <= bus.mem_instr;
            lat_ram_hit  <= cur_ram_hit;
            lat_port_hit <= cur_port_hit;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt    <= 4'd0;
            bus.mem_rdata <= 32'h0000_0000;
            out_data    <= 8'h00;
            fetch_count <= 32'h0000_0000;
        end else begin
            if (accept) begin
                wait_cnt <= WAIT_LOAD;
            end else if ((state == WAIT) && (wait_cnt != 4'd0)) begin
                wait_cnt <= wait_cnt - 4'd1;
            end

            // Read data is captured on the edge that enters RESP so it is
            // on the bus for the whole mem_ready cycle.
            if (next_state == RESP) begin
                if (rd_ram_hit) begin
                    bus.mem_rdata <= ram[rd_idx];
                end else if (rd_port_hit) begin
                    bus.mem_rdata <= 32'h0000_0000;
                end else begin
                    bus.mem_rdata <= 32'hDEAD_BEEF;
                end
            end

            if (state == RESP) begin
                if (lat_port_hit && lat_wstrb[0]) begin
                    out_data <= lat_wdata[7:0];
                end
                if (lat_instr && (lat_wstrb == 4'h0)) begin
                    fetch_count <= fetch_count + 32'd1;
                end
            end
        end
    end

    // Writes commit on the edge leaving RESP; a reset on that edge cancels them.
    always_ff @(posedge clk) begin
        if (!reset && (state == RESP) && lat_ram_hit) begin
            for (int i = 0; i < 4; i++) begin
                if (lat_wstrb[i]) begin
                    ram[lat_idx][8*i +: 8] <= lat_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: doc/picorv32_mem_ram.md
# picorv32_mem_ram

Word-organised on-chip RAM slave for the picorv32 native memory interface, with a single byte-wide output port mapped at a fixed address. Sits directly downstream of the core: it consumes `mem_valid`/`mem_addr`/`mem_wdata`/`mem_wstrb`/`mem_instr` and produces `mem_ready`/`mem_rdata`. It has programmable wait states, an out-of-range error pulse and an instruction-fetch counter for bring-up and area/timing experiments.

## Interface
- `MEM_WORDS`, default 1024: RAM depth in 32-bit words; any value ≥ 1.
- `BASE_ADDR`, default 32'h0000_0000: byte address of RAM word 0; word-aligned.
- `WAIT_STATES`, default 0: extra cycles inserted before `mem_ready`; range 0..15.
- `OUT_ADDR`, default 32'h1000_0000: byte address of the output port; word-aligned and outside the RAM range.
- `clk`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `mem_valid`  in  1  request valid from the core.
- `mem_instr`  in  1  request is an instruction fetch.
- `mem_ready`  out  1  one-cycle completion strobe.
- `mem_addr`  in  32  byte address; bits [1:0] are ignored.
- `mem_wdata`  in  32  write data.
- `mem_wstrb`  in  4  byte write enables; 4'b0000 means read.
- `mem_rdata`  out  32  read data, valid while `mem_ready`=1.
- `out_valid`  out  1  one-cycle strobe on a write to `OUT_ADDR`.
- `out_data`  out  8  last byte written to `OUT_ADDR`.
- `err`  out  1  one-cycle strobe on an access that hits neither RAM nor `OUT_ADDR`.
- `fetch_count`  out  32  number of completed `mem_instr` reads.

## Operation
- Decode uses `mem_addr[31:2]`:
  - RAM hit when `BASE_ADDR[31:2]` ≤ word < `BASE_ADDR[31:2]+MEM_WORDS`.
  - Port hit when word = `OUT_ADDR[31:2]`.
  - Otherwise the access is a miss.
- FSM states are IDLE, WAIT, RESP and RECOVER.
  - IDLE: when `mem_valid`=1, latch address, data, strobe, instr flag and decode result. Go to WAIT if `WAIT_STATES`>0, else to RESP.
  - WAIT: a counter loaded with `WAIT_STATES`-1 decrements each cycle. Go to RESP when it reaches 0.
  - RESP: `mem_ready`=1 for exactly one cycle, then go to RECOVER.
  - RECOVER: `mem_ready`=0 for one cycle, then go to IDLE. The core drops or changes `mem_valid` during this cycle.
- RAM read: `mem_rdata` = the addressed word, registered. RAM contents are not reset.
- RAM write: takes effect at the RESP edge, byte lane i gated by `mem_wstrb[i]`. A read of the same word issued afterwards returns the merged value.
- Port write:
  - `out_valid`=1 in the RESP cycle.
  - If `mem_wstrb[0]`=1, `out_data` ← `mem_wdata[7:0]` at the same edge. Otherwise `out_data` holds its value and `out_valid` still pulses.
- Port read returns 32'h0000_0000.
- Miss:
  - `err`=1 in the RESP cycle.
  - A read returns 32'hDEAD_BEEF. A write has no effect.
  - `mem_ready` still pulses, so the core never hangs.
- `fetch_count` increments (wrapping at 2^32) at the RESP edge of any access with latched `mem_instr`=1 and `mem_wstrb`=0, including misses.
- If `mem_valid` drops while in WAIT, abort to IDLE: no write, no `mem_ready`, no `err`, no `out_valid`, no count. The core never does this; the rule only makes behaviour deterministic.

## Timing
- Reset values:
  - state IDLE.
  - `mem_ready`, `out_valid` and `err` = 0.
  - `mem_rdata` = 0.
  - `out_data` = 8'h00.
  - `fetch_count` = 0.
- Latency: if `mem_valid` is first high in cycle N, `mem_ready`=1 in cycle N+1+`WAIT_STATES`.
- Throughput: one access per `WAIT_STATES`+3 cycles. Back-to-back requests are accepted in the first IDLE cycle after RECOVER.
- `mem_ready` is never high in two consecutive cycles. `err`, `out_valid` and `mem_ready` pulse in the same cycle.
- `mem_rdata` is undefined-but-stable outside RESP: it holds its last value.
- Reset asserted in any state:
  - Next cycle is IDLE with all strobes 0.
  - A write in WAIT or RESP is not committed if reset is high on the RESP edge.
  - `fetch_count` returns to 0.
- The latched request is used throughout. Input changes after acceptance are ignored, except `mem_valid` low in WAIT (abort).

## Test plan
- `WAIT_STATES`=0: write 32'h1234_5678 with strobe 4'hF to `BASE_ADDR`+8, then read it back -> `mem_ready` 1 cycle after each request; read returns 32'h1234_5678. Verify the RECOVER gap.
- Byte-lane merge: write 32'hAABB_CCDD with strobe 4'hF, then 32'h0000_EE00 with strobe 4'b0010 to the same word -> read returns 32'hAABB_EEDD.
- `WAIT_STATES`=3: read at cycle N -> `mem_ready` exactly at N+4; no earlier strobe.
- Port and miss:
  - Write 32'h0000_0041 to `OUT_ADDR` -> `out_valid` pulse, `out_data`=8'h41.
  - Read `BASE_ADDR`+4*`MEM_WORDS` -> `err` pulse, data 32'hDEAD_BEEF.
  - Write to the same missed address -> `err` pulse, no RAM change.
- Counter: 5 instruction fetches, 2 data reads, 1 fetch to a miss address -> `fetch_count`=6. Assert `reset` -> `fetch_count`=0.
- Reset mid-operation: with `WAIT_STATES`=3, assert `reset` during WAIT of a write -> no `mem_ready`, target word unchanged on later read, FSM accepts the next request normally.
